fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_VEC, default 32'h0000_0000: id_pc value held while id_valid=0 after reset.
REQ-002 Ports:
  clock        in   1   single clock, rising edge
  reset        in   1   asynchronous, active-high
  pc           in   32  current PC register output
  pc_advance   out  1   PC may load pc+4 at this edge
  imem_req     out  1   instruction memory request
  imem_addr    out  32  request address
  imem_ack     in   1   memory data valid, 1-cycle pulse
  imem_rdata   in   32  instruction word
  flush        in   1   redirect (branch/jump); PC mux owns next PC
  id_ready     in   1   decode accepts id_* this cycle
  id_valid     out  1   IF/ID register holds an instruction
  id_instr     out  32  fetched instruction
  id_pc        out  32  address of id_instr
  id_pc_plus4  out  32  id_pc+4
  fetch_fault  out  1   misaligned PC detected, sticky
REQ-003 One clock, named clock; reset asynchronous active-high, named reset.

Function
REQ-004 FSM states: IDLE, FETCH, DRAIN, FAULT.
REQ-005 IDLE -> FETCH on the first edge with reset low; no request in IDLE.
REQ-006 FETCH: imem_req=1 iff pc[1:0]==0 and (id_valid==0 or id_ready==1); imem_addr=pc.
REQ-007 Once imem_req rises, it and imem_addr hold stable until the imem_ack cycle, regardless of id_ready.
REQ-008 FETCH with imem_ack=1, flush=0: at that edge id_instr<=imem_rdata, id_pc<=imem_addr, id_pc_plus4<=imem_addr+4 (mod 2^32; 32'hFFFF_FFFC -> 32'h0), id_valid<=1.
REQ-009 pc_advance combinational = (state==FETCH) & imem_ack & ~flush; asserted the same cycle as the capture.
REQ-010 Back-to-back: a new request is permitted in the cycle after an ack; sustained throughput 1 instruction per memory latency+1 cycles.
REQ-011 id_valid clears at an edge with id_ready=1 and no capture; with capture, id_valid stays 1 (new data).
REQ-012 id_valid=1, id_ready=0: id_* hold; no new request issued.
REQ-013 flush=1: id_valid<=0 at that edge; pc_advance=0; any imem_ack that cycle discarded.
REQ-014 flush=1 with request outstanding and no ack that cycle: FETCH -> DRAIN; DRAIN keeps imem_req=1, old imem_addr; on ack discard data, -> FETCH.
REQ-015 flush during DRAIN: stay DRAIN; a single outstanding request is drained once.
REQ-016 FETCH with pc[1:0]!=0 and no request outstanding: -> FAULT, fetch_fault<=1, no request.
REQ-017 FAULT: imem_req=0, pc_advance=0; flush=1 -> FETCH and fetch_fault<=0.
REQ-018 Never more than one request outstanding.

Reset
REQ-019 Asynchronous reset: state=IDLE, imem_req=0, pc_advance=0, id_valid=0, id_instr=32'h0, id_pc=RESET_VEC, id_pc_plus4=RESET_VEC+4, fetch_fault=0.
REQ-020 Reset mid-request abandons the transaction; an imem_ack in the first post-reset cycle is ignored.

Structure
REQ-021 Shared package cpu_pkg: FSM state enum, PC_STEP=4, INSTR_NOP=32'h0, RESET_VEC default.
REQ-022 One sub-module, if_id_reg (id_* storage with load/clear/hold); FSM and handshake in fetch_unit.

Verification
REQ-023 Reset release, pc=0x0, ack after 2 cycles with 0x2010_0005 -> id_instr=0x2010_0005, id_pc=0x0, id_pc_plus4=0x4, one pc_advance pulse.
REQ-024 Zero-wait memory, id_ready=1, 4 fetches from 0x100 -> id_pc 0x100,0x104,0x108,0x10C on successive captures, one request in flight.
REQ-025 id_ready=0 for 3 cycles with id_valid=1 -> id_* stable, imem_req=0, pc_advance=0.
REQ-026 flush while request to 0x200 outstanding, ack 2 cycles later -> DRAIN, data discarded, id_valid=0, next request at redirected pc 0x400.
REQ-027 pc=0x1002 -> fetch_fault=1, imem_req=0; flush with pc=0x1000 -> fault clears, request at 0x1000.
REQ-028 pc=0xFFFF_FFFC fetched -> id_pc_plus4=0x0000_0000; reset asserted mid-request -> all outputs at reset values same cycle.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared types and constants for the instruction fetch path.
package cpu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAIN = 2'd2,
    ST_FAULT = 2'd3
  } fetch_state_e;

  localparam logic [31:0] PC_STEP           = 32'd4;
  localparam logic [31:0] INSTR_NOP         = 32'h0000_0000;
  localparam logic [31:0] RESET_VEC_DEFAULT = 32'h0000_0000;

  // Sequential successor of a PC; wraps modulo 2^32.
  function automatic logic [31:0] pc_plus_step(input logic [31:0] pc_val);
    return pc_val + PC_STEP;
  endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: load wins over drop; drop only clears the valid bit.
module if_id_reg
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_VEC = RESET_VEC_DEFAULT
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        load_i,
  input  logic        drop_i,
  input  logic [31:0] instr_i,
  input  logic [31:0] pc_i,
  output logic        valid_o,
  output logic [31:0] instr_o,
  output logic [31:0] pc_o,
  output logic [31:0] pc_plus4_o
);

  logic        valid_q, valid_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] pc4_q, pc4_d;

  always_comb begin
    valid_d = valid_q;
    instr_d = instr_q;
    pc_d    = pc_q;
    pc4_d   = pc4_q;
    if (load_i) begin
      valid_d = 1'b1;
      instr_d = instr_i;
      pc_d    = pc_i;
      pc4_d   = pc_plus_step(pc_i);
    end else if (drop_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      valid_q <= 1'b0;
      instr_q <= INSTR_NOP;
      pc_q    <= RESET_VEC;
      pc4_q   <= pc_plus_step(RESET_VEC);
    end else begin
      valid_q <= valid_d;
      instr_q <= instr_d;
      pc_q    <= pc_d;
      pc4_q   <= pc4_d;
    end
  end

  assign valid_o    = valid_q;
  assign instr_o    = instr_q;
  assign pc_o       = pc_q;
  assign pc_plus4_o = pc4_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: single-outstanding memory handshake, flush draining,
// misaligned-PC fault, and the IF/ID register.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_VEC = RESET_VEC_DEFAULT
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] pc,
  output logic        pc_advance,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        flush,
  input  logic        id_ready,
  output logic        id_valid,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  output logic [31:0] id_pc_plus4,
  output logic        fetch_fault
);

  fetch_state_e state_q, state_d;
  logic         pend_q, pend_d;    // request issued in FETCH, ack not yet seen
  logic [31:0]  addr_q, addr_d;
  logic         fault_q, fault_d;
  logic         pc_aligned;
  logic         can_issue;

  assign pc_aligned = (pc[1:0] == 2'b00);
  assign can_issue  = pc_aligned & (~id_valid | id_ready);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      pend_q  <= 1'b0;
      addr_q  <= 32'h0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      addr_q  <= addr_d;
      fault_q <= fault_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    addr_d  = addr_q;
    fault_d = fault_q;
    case (state_q)
      ST_IDLE: state_d = ST_FETCH;
      ST_FETCH: begin
        // Latch the address on issue so it stays put until the ack.
        if (imem_req && !pend_q) addr_d = pc;
        if (flush) begin
          pend_d = 1'b0;
          if (imem_req && !imem_ack) state_d = ST_DRAIN;
        end else if (imem_req) begin
          pend_d = ~imem_ack;
        end else if (!pc_aligned) begin
          state_d = ST_FAULT;
          fault_d = 1'b1;
        end
      end
      ST_DRAIN: begin
        if (imem_ack) state_d = ST_FETCH;
      end
      ST_FAULT: begin
        if (flush) begin
          state_d = ST_FETCH;
          fault_d = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    imem_req   = 1'b0;
    imem_addr  = pc;
    pc_advance = 1'b0;
    case (state_q)
      ST_FETCH: begin
        if (pend_q) begin
          imem_req  = 1'b1;
          imem_addr = addr_q;
        end else begin
          imem_req  = can_issue;
        end
        pc_advance = imem_req & imem_ack & ~flush;
      end
      ST_DRAIN: begin
        imem_req  = 1'b1;
        imem_addr = addr_q;
      end
      default: begin
        imem_req = 1'b0;
      end
    endcase
  end

  assign fetch_fault = fault_q;

  if_id_reg #(
    .RESET_VEC(RESET_VEC)
  ) u_if_id (
    .clock      (clock),
    .reset      (reset),
    .load_i     (pc_advance),
    .drop_i     (flush | id_ready),
    .instr_i    (imem_rdata),
    .pc_i       (imem_addr),
    .valid_o    (id_valid),
    .instr_o    (id_instr),
    .pc_o       (id_pc),
    .pc_plus4_o (id_pc_plus4)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: vector table, directed corner sequences,
// and a randomized run against a transaction-level program-order model.
module tb_fetch_unit;

  localparam logic [31:0] RV = 32'h0000_0080;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] pc = 32'h0;
  logic        pc_advance;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic        flush = 1'b0;
  logic        id_ready = 1'b0;
  logic        id_valid;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic [31:0] id_pc_plus4;
  logic        fetch_fault;

  int n_tests = 0;
  int n_fail  = 0;

  fetch_unit #(.RESET_VEC(RV)) dut (
    .clock       (clock),
    .reset       (reset),
    .pc          (pc),
    .pc_advance  (pc_advance),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .flush       (flush),
    .id_ready    (id_ready),
    .id_valid    (id_valid),
    .id_instr    (id_instr),
    .id_pc       (id_pc),
    .id_pc_plus4 (id_pc_plus4),
    .fetch_fault (fetch_fault)
  );

  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [31:0] pc;
    logic        ack;
    logic [31:0] rdata;
    logic        flush;
    logic        rdy;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_adv;
    logic        e_valid;
    logic [31:0] e_instr;
    logic [31:0] e_pc;
    logic [31:0] e_pc4;
    logic        e_fault;
  } vec_t;

  vec_t vecs [15];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0F1E_2D3C;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one cycle's inputs at the falling edge, then let combinational outputs settle.
  task automatic apply(input logic [31:0] p, input logic a, input logic [31:0] d,
                       input logic f, input logic r);
    @(negedge clock);
    reset      = 1'b0;
    pc         = p;
    imem_ack   = a;
    imem_rdata = d;
    flush      = f;
    id_ready   = r;
    #1;
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset    = 1'b1;
    imem_ack = 1'b0;
    flush    = 1'b0;
    id_ready = 1'b0;
    repeat (2) @(negedge clock);
  endtask

  initial begin : main
    logic [31:0] p;
    logic [31:0] pc_nxt, tgt, exp_pc, maddr;
    logic        busy, killed, exp_adv;
    int          k, adv_cnt, lat, consumed;

    //            pc            ack   rdata         fl    rdy   req   addr          adv   val   instr         id_pc         pc4           flt
    vecs[0]  = '{32'h0,        1'b1, 32'hDEAD_BEEF, 1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        RV,           RV + 32'd4,   1'b0};
    vecs[1]  = '{32'h0,        1'b0, 32'h0,        1'b0, 1'b1, 1'b1, 32'h0,        1'b0, 1'b0, 32'h0,        RV,           RV + 32'd4,   1'b0};
    vecs[2]  = '{32'h0,        1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 32'h0,        1'b0, 1'b0, 32'h0,        RV,           RV + 32'd4,   1'b0};
    vecs[3]  = '{32'h0,        1'b1, 32'h2010_0005, 1'b0, 1'b0, 1'b1, 32'h0,        1'b1, 1'b0, 32'h0,        RV,           RV + 32'd4,   1'b0};
    vecs[4]  = '{32'h4,        1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 32'h2010_0005, 32'h0,       32'h4,        1'b0};
    vecs[5]  = '{32'h4,        1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 32'h2010_0005, 32'h0,       32'h4,        1'b0};
    vecs[6]  = '{32'h4,        1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 32'h2010_0005, 32'h0,       32'h4,        1'b0};
    vecs[7]  = '{32'h4,        1'b0, 32'h0,        1'b0, 1'b1, 1'b1, 32'h4,        1'b0, 1'b1, 32'h2010_0005, 32'h0,       32'h4,        1'b0};
    vecs[8]  = '{32'h4,        1'b1, 32'h1111_1111, 1'b0, 1'b1, 1'b1, 32'h4,        1'b1, 1'b0, 32'h2010_0005, 32'h0,       32'h4,        1'b0};
    vecs[9]  = '{32'h1002,     1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 1'b1, 32'h1111_1111, 32'h4,       32'h8,        1'b0};
    vecs[10] = '{32'h1002,     1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 32'h1111_1111, 32'h4,       32'h8,        1'b1};
    vecs[11] = '{32'h1000,     1'b0, 32'h0,        1'b1, 1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 32'h1111_1111, 32'h4,       32'h8,        1'b1};
    vecs[12] = '{32'h1000,     1'b0, 32'h0,        1'b0, 1'b1, 1'b1, 32'h1000,     1'b0, 1'b0, 32'h1111_1111, 32'h4,       32'h8,        1'b0};
    vecs[13] = '{32'h1000,     1'b1, 32'h3333_3333, 1'b0, 1'b1, 1'b1, 32'h1000,     1'b1, 1'b0, 32'h1111_1111, 32'h4,       32'h8,        1'b0};
    vecs[14] = '{32'h1004,     1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 32'h3333_3333, 32'h1000,    32'h1004,     1'b0};

    // Vector table: reset state, first fetch, decode stall, misaligned fault and recovery.
    do_reset();
    for (int i = 0; i < 15; i++) begin
      apply(vecs[i].pc, vecs[i].ack, vecs[i].rdata, vecs[i].flush, vecs[i].rdy);
      chk($sformatf("vec%0d.req_adv_val_flt", i),
          32'({imem_req, pc_advance, id_valid, fetch_fault}),
          32'({vecs[i].e_req, vecs[i].e_adv, vecs[i].e_valid, vecs[i].e_fault}));
      if (vecs[i].e_req) chk($sformatf("vec%0d.imem_addr", i), imem_addr, vecs[i].e_addr);
      chk($sformatf("vec%0d.id_instr", i), id_instr, vecs[i].e_instr);
      chk($sformatf("vec%0d.id_pc", i), id_pc, vecs[i].e_pc);
      chk($sformatf("vec%0d.id_pc_plus4", i), id_pc_plus4, vecs[i].e_pc4);
    end

    // Zero-wait memory, decode always ready: one capture per cycle from 0x100.
    do_reset();
    p = 32'h100;
    k = 0;
    adv_cnt = 0;
    for (int c = 0; c < 6; c++) begin
      apply(p, 1'b0, 32'h0, 1'b0, 1'b1);
      if (imem_req) begin
        imem_ack   = 1'b1;
        imem_rdata = mem_word(imem_addr);
        #1;
      end
      if (c >= 2 && k < 4) begin
        chk("zw.id_valid", 32'(id_valid), 32'h1);
        chk("zw.id_pc", id_pc, 32'h100 + 32'(4 * k));
        k++;
      end
      if (pc_advance) begin
        adv_cnt++;
        p = p + 32'd4;
      end
    end
    chk("zw.advance_count", 32'(adv_cnt), 32'd5);

    // Flush with a request outstanding: drain old address, then fetch redirect target.
    do_reset();
    apply(32'h200, 1'b0, 32'h0, 1'b0, 1'b1);
    apply(32'h200, 1'b0, 32'h0, 1'b0, 1'b1);
    chk("fl.req_issue", 32'({imem_req, imem_addr == 32'h200}), 32'h3);
    apply(32'h200, 1'b0, 32'h0, 1'b1, 1'b1);
    chk("fl.req_during_flush", 32'({imem_req, pc_advance}), 32'h2);
    apply(32'h400, 1'b0, 32'h0, 1'b1, 1'b1);
    chk("fl.drain_addr_held", imem_addr, 32'h200);
    chk("fl.drain_req", 32'(imem_req), 32'h1);
    apply(32'h400, 1'b1, 32'hBAD0_BAD0, 1'b0, 1'b1);
    chk("fl.drain_ack_no_adv", 32'({imem_req, pc_advance}), 32'h2);
    apply(32'h400, 1'b0, 32'h0, 1'b0, 1'b1);
    chk("fl.id_valid_after_drain", 32'(id_valid), 32'h0);
    chk("fl.redirect_addr", imem_addr, 32'h400);
    chk("fl.redirect_req", 32'(imem_req), 32'h1);
    apply(32'h400, 1'b1, mem_word(32'h400), 1'b0, 1'b1);
    chk("fl.redirect_adv", 32'(pc_advance), 32'h1);
    apply(32'h404, 1'b0, 32'h0, 1'b0, 1'b0);
    chk("fl.redirect_id_pc", id_pc, 32'h400);
    chk("fl.redirect_id_instr", id_instr, mem_word(32'h400));

    // PC wrap, then reset asserted mid-request and an ack right after release.
    do_reset();
    apply(32'hFFFF_FFFC, 1'b0, 32'h0, 1'b0, 1'b1);
    apply(32'hFFFF_FFFC, 1'b1, 32'hCAFE_F00D, 1'b0, 1'b1);
    chk("wrap.adv", 32'(pc_advance), 32'h1);
    apply(32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
    chk("wrap.id_pc", id_pc, 32'hFFFF_FFFC);
    chk("wrap.id_pc_plus4", id_pc_plus4, 32'h0);
    apply(32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
    chk("rst.req_before", 32'({imem_req, imem_addr == 32'h0}), 32'h3);
    reset = 1'b1;
    #1;
    chk("rst.req_adv_val_flt", 32'({imem_req, pc_advance, id_valid, fetch_fault}), 32'h0);
    chk("rst.id_instr", id_instr, 32'h0);
    chk("rst.id_pc", id_pc, RV);
    chk("rst.id_pc_plus4", id_pc_plus4, RV + 32'd4);
    apply(32'h40, 1'b1, 32'h7777_7777, 1'b0, 1'b1);
    chk("rst.post_ack_ignored", 32'({imem_req, pc_advance}), 32'h0);
    apply(32'h40, 1'b0, 32'h0, 1'b0, 1'b1);
    chk("rst.post_no_capture", 32'(id_valid), 32'h0);
    chk("rst.fresh_addr", imem_addr, 32'h40);

    // Randomized run: memory with random latency, random decode stalls and redirects.
    do_reset();
    pc_nxt   = 32'h1000;
    exp_pc   = 32'h1000;
    busy     = 1'b0;
    killed   = 1'b0;
    maddr    = 32'h0;
    lat      = 0;
    consumed = 0;
    apply(pc_nxt, 1'b0, 32'h0, 1'b0, 1'b1);
    for (int cyc = 0; cyc < 3000; cyc++) begin
      tgt = 32'($urandom_range(0, 4095)) << 2;
      apply(pc_nxt, 1'b0, 32'h0, ($urandom_range(0, 15) == 0), ($urandom_range(0, 9) < 7));
      if (!busy && imem_req) begin
        busy   = 1'b1;
        killed = 1'b0;
        maddr  = imem_addr;
        lat    = $urandom_range(0, 3);
      end else if (busy) begin
        chk("rand.req_stable", 32'({imem_req, imem_addr == maddr}), 32'h3);
      end
      if (busy && lat == 0) begin
        imem_ack   = 1'b1;
        imem_rdata = mem_word(maddr);
      end
      #1;
      exp_adv = imem_ack && !killed && !flush;
      chk("rand.pc_advance", 32'(pc_advance), 32'(exp_adv));
      if (id_valid && id_ready && !flush) begin
        chk("rand.id_pc", id_pc, exp_pc);
        chk("rand.id_instr", id_instr, mem_word(exp_pc));
        chk("rand.id_pc_plus4", id_pc_plus4, exp_pc + 32'd4);
        exp_pc = exp_pc + 32'd4;
        consumed++;
      end
      if (flush) exp_pc = tgt;
      if (flush && busy) killed = 1'b1;
      if (imem_ack) busy = 1'b0;
      else if (busy) lat--;
      pc_nxt = flush ? tgt : (pc_advance ? pc + 32'd4 : pc);
    end
    chk("rand.progress", 32'(consumed >= 200), 32'h1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
